wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: MDU_FIFO_DEPTH, default 2, depth of the multiply/divide result queue; legal values 2 or 4.
REQ-002 clk  in  1  single clock; all state updates on rising edge; regfile consumes rf_* on its falling-edge write.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 mem_valid  in  1  MEM stage presents an instruction.
REQ-005 mem_ready  out  1  wb_stage accepts the MEM instruction this cycle; combinational.
REQ-006 mem_wen  in  1  instruction writes a GPR.
REQ-007 mem_rd  in  5  destination register.
REQ-008 mem_result  in  32  ALU/link result for non-load writes.
REQ-009 mem_is_load  in  1  result comes from mem_rdata.
REQ-010 mem_ld_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes treated as LW.
REQ-011 mem_addr_lo  in  2  low bits of the load address.
REQ-012 mem_rdata  in  32  raw aligned word from data memory.
REQ-013 mdu_valid  in  1  multi-cycle mul/div unit presents a result.
REQ-014 mdu_ready  out  1  high when queue count < MDU_FIFO_DEPTH; combinational.
REQ-015 mdu_rd  in  5  / mdu_result  in  32  destination and value.
REQ-016 rf_wen  out  1  / rf_waddr  out  5  / rf_wdata  out  32  registered regfile write port.
REQ-017 wb_misalign  out  1  one-cycle pulse: misaligned load dropped.
REQ-018 wb_retired  out  32  count of MEM instructions accepted.

Function
REQ-019 A MEM instruction is accepted when mem_valid && mem_ready; its write appears on rf_* at the next rising edge (1-cycle latency).
REQ-020 mem_ready SHALL be 0 only when the queue is full; while it is 0 the queue head drains.
REQ-021 A GPR write occurs at most once per cycle; an accepted MEM write (mem_wen, mem_rd != 0) has priority over the queue head.
REQ-022 The queue head is written when no MEM write is accepted that cycle; pop and push in the same cycle are legal at any count below full.
REQ-023 Load extraction: little-endian; LB/LBU select byte mem_addr_lo; LH/LHU select halfword mem_addr_lo[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 LH/LHU with mem_addr_lo[0]=1, or LW with mem_addr_lo != 0: write suppressed, wb_misalign=1 next cycle, instruction still counted retired.
REQ-025 Writes with rd=0 are never issued (rf_wen=0), from either source.
REQ-026 WAW: an accepted MEM write to rd=R invalidates every queued entry with rd=R; invalidated entries pop without writing.
REQ-027 An mdu result pushed in the same cycle as an accepted MEM write to the same rd is consumed and discarded.
REQ-028 rf_wen=0 on any cycle with no valid write; rf_waddr/rf_wdata hold their previous values.
REQ-029 wb_retired wraps from 0xFFFFFFFF to 0.

Reset
REQ-030 On rst: rf_wen=0, rf_waddr=0, rf_wdata=0, wb_misalign=0, wb_retired=0, queue emptied (mdu_ready=1, mem_ready=1).
REQ-031 rst asserted mid-operation discards all queued entries and any pending write; no write issues in the cycle reset deasserts.

Structure
REQ-032 mem_ld_type codes and the GPR index width belong in the shared package cpu_defs.
REQ-033 The queue SHALL be a sub-module wb_fifo (depth MDU_FIFO_DEPTH, per-entry valid bit supporting rd-match invalidation).

Verification
REQ-034 Reset, then MEM LW rd=3, result 0x12345678 -> next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x12345678; wb_retired=1.
REQ-035 LB addr_lo=2, rdata=0x0080FF00 -> wdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr_lo=2, rdata=0x8001_0000 -> 0x00008001.
REQ-036 LH addr_lo=1 -> rf_wen=0, wb_misalign pulses one cycle, wb_retired increments.
REQ-037 Push two mdu results (rd=4,5) while MEM writes every cycle -> mdu_ready=0, mem_ready=0 one cycle, rd=4 written, then mem_ready=1.
REQ-038 Queue holds rd=7 value 0xAAAA; MEM writes rd=7 value 0x5555 -> rd=7 ends 0x5555, no later write of 0xAAAA.
REQ-039 Write to rd=0 from each source -> rf_wen stays 0; rst asserted with 2 queued -> no writes after release.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: GPR index width, load-type encodings and the
// load alignment/extraction helpers used by the writeback stage.
package cpu_defs;

  localparam int GPR_IDX_W = 5;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } ld_type_e;

  // Unknown load codes behave as LW, so they need word alignment.
  function automatic logic ld_misaligned(input logic [2:0] ld_type,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (ld_type)
      LD_B, LD_BU: bad = 1'b0;
      LD_H, LD_HU: bad = addr_lo[0];
      default:     bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] ld_extract(input logic [2:0]  ld_type,
                                             input logic [1:0]  addr_lo,
                                             input logic [31:0] rdata);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] value;
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_type)
      LD_B:    value = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   value = {24'h000000, byte_sel};
      LD_H:    value = {{16{half_sel[15]}}, half_sel};
      LD_HU:   value = {16'h0000, half_sel};
      default: value = rdata;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result queue for the multi-cycle mul/div unit. Each entry carries a valid
// bit so a younger MEM write can cancel it in place without reordering.
module wb_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [GPR_IDX_W-1:0] push_rd,
  input  logic [31:0]          push_data,
  input  logic                 pop,
  input  logic                 inv_en,
  input  logic [GPR_IDX_W-1:0] inv_rd,
  output logic                 head_valid,
  output logic [GPR_IDX_W-1:0] head_rd,
  output logic [31:0]          head_data,
  output logic                 empty,
  output logic                 full
);

  // DEPTH is a power of two, so the pointers wrap on their own.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     ent_valid;
  logic [GPR_IDX_W-1:0] ent_rd   [DEPTH];
  logic [31:0]          ent_data [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;

  // Cancellation is applied before the push so a fresh entry is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (inv_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_rd[i] == inv_rd) ent_valid[i] <= 1'b0;
        end
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_rd[wr_ptr]    <= push_rd;
        ent_data[wr_ptr]  <= push_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign head_valid = !empty && ent_valid[rd_ptr];
  assign head_rd    = ent_rd[rd_ptr];
  assign head_data  = ent_data[rd_ptr];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges MEM-stage results and queued mul/div results onto a
// single registered regfile write port, with load extraction and WAW cancel.
module wb_stage
  import cpu_defs::*;
#(
  parameter int MDU_FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic                 mem_wen,
  input  logic [GPR_IDX_W-1:0] mem_rd,
  input  logic [31:0]          mem_result,
  input  logic                 mem_is_load,
  input  logic [2:0]           mem_ld_type,
  input  logic [1:0]           mem_addr_lo,
  input  logic [31:0]          mem_rdata,
  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic [GPR_IDX_W-1:0] mdu_rd,
  input  logic [31:0]          mdu_result,
  output logic                 rf_wen,
  output logic [GPR_IDX_W-1:0] rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 wb_misalign,
  output logic [31:0]          wb_retired
);

  logic                 q_head_valid;
  logic [GPR_IDX_W-1:0] q_head_rd;
  logic [31:0]          q_head_data;
  logic                 q_empty;
  logic                 q_full;
  logic                 q_push;
  logic                 q_pop;

  logic                 mem_accept;
  logic                 mem_bad_align;
  logic                 mem_write;
  logic                 head_write;
  logic [31:0]          mem_wdata;

  // A suppressed misaligned load does not claim the port and cancels nothing.
  // Cancelled heads drain even while a MEM write owns the port; rd=0 mdu
  // results and results overwritten in the same cycle never enter the queue.
  always_comb begin
    mem_accept    = mem_valid && !q_full;
    mem_bad_align = mem_is_load && ld_misaligned(mem_ld_type, mem_addr_lo);
    mem_write     = mem_accept && mem_wen && (mem_rd != '0) && !mem_bad_align;
    mem_wdata     = mem_is_load ? ld_extract(mem_ld_type, mem_addr_lo, mem_rdata)
                                : mem_result;
    q_pop         = !q_empty && (!q_head_valid || !mem_write);
    head_write    = q_pop && q_head_valid;
    q_push        = mdu_valid && !q_full && (mdu_rd != '0) &&
                    !(mem_write && (mdu_rd == mem_rd));
  end

  assign mem_ready = !q_full;
  assign mdu_ready = !q_full;

  wb_fifo #(
    .DEPTH (MDU_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_rd    (mdu_rd),
    .push_data  (mdu_result),
    .pop        (q_pop),
    .inv_en     (mem_write),
    .inv_rd     (mem_rd),
    .head_valid (q_head_valid),
    .head_rd    (q_head_rd),
    .head_data  (q_head_data),
    .empty      (q_empty),
    .full       (q_full)
  );

  // Address and data hold their last value on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen      <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      wb_misalign <= 1'b0;
      wb_retired  <= '0;
    end else begin
      rf_wen      <= mem_write || head_write;
      wb_misalign <= mem_accept && mem_bad_align;
      wb_retired  <= wb_retired + 32'(mem_accept);
      if (mem_write) begin
        rf_waddr <= mem_rd;
        rf_wdata <= mem_wdata;
      end else if (head_write) begin
        rf_waddr <= q_head_rd;
        rf_wdata <= q_head_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_wb_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_result;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_misalign;
  logic [31:0] wb_retired;

  wb_stage #(.MDU_FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_wen     (mem_wen),
    .mem_rd      (mem_rd),
    .mem_result  (mem_result),
    .mem_is_load (mem_is_load),
    .mem_ld_type (mem_ld_type),
    .mem_addr_lo (mem_addr_lo),
    .mem_rdata   (mem_rdata),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_rd      (mdu_rd),
    .mdu_result  (mdu_result),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .wb_misalign (wb_misalign),
    .wb_retired  (wb_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        live;
    bit [4:0]  rd;
    bit [31:0] val;
  } q_ent_t;

  q_ent_t    mq[$];
  bit        exp_wen;
  bit [4:0]  exp_waddr;
  bit [31:0] exp_wdata;
  bit        exp_mis;
  bit [31:0] exp_ret;
  int        tests_run;
  int        tests_failed;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit refMisaligned(input bit [2:0] t, input bit [1:0] lo);
    if (t == 3'd1 || t == 3'd2) return 1'b0;
    if (t == 3'd3 || t == 3'd4) return (int'(lo) % 2) != 0;
    return lo != 2'd0;
  endfunction

  function automatic bit [31:0] refLoad(input bit [2:0] t, input bit [1:0] lo,
                                        input bit [31:0] w);
    bit [31:0] b;
    bit [31:0] h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
    case (t)
      3'd1:    return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  task automatic modelReset();
    mq.delete();
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_mis   = 1'b0;
    exp_ret   = '0;
  endtask

  task automatic applyStimulus(input bit mv, input bit wen, input bit [4:0] rd,
                               input bit [31:0] res, input bit ld, input bit [2:0] lt,
                               input bit [1:0] lo, input bit [31:0] rdat,
                               input bit dv, input bit [4:0] drd, input bit [31:0] dres);
    mem_valid   = mv;
    mem_wen     = wen;
    mem_rd      = rd;
    mem_result  = res;
    mem_is_load = ld;
    mem_ld_type = lt;
    mem_addr_lo = lo;
    mem_rdata   = rdat;
    mdu_valid   = dv;
    mdu_rd      = drd;
    mdu_result  = dres;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic runCycle();
    bit        full;
    bit        acc;
    bit        bad;
    bit        mw;
    bit [31:0] val;
    #1;
    full = (mq.size() == DEPTH);
    checkOutput("mem_ready", 32'(mem_ready), 32'(!full));
    checkOutput("mdu_ready", 32'(mdu_ready), 32'(!full));
    acc = mem_valid && !full;
    bad = acc && mem_is_load && refMisaligned(mem_ld_type, mem_addr_lo);
    mw  = acc && mem_wen && (mem_rd != 0) && !bad;
    val = mem_is_load ? refLoad(mem_ld_type, mem_addr_lo, mem_rdata) : mem_result;
    exp_wen = 1'b0;
    if (mw) begin
      exp_wen   = 1'b1;
      exp_waddr = mem_rd;
      exp_wdata = val;
    end
    if (mq.size() > 0) begin
      if (!mq[0].live) begin
        mq.delete(0);
      end else if (!mw) begin
        exp_wen   = 1'b1;
        exp_waddr = mq[0].rd;
        exp_wdata = mq[0].val;
        mq.delete(0);
      end
    end
    if (mw) begin
      foreach (mq[i]) if (mq[i].rd == mem_rd) mq[i].live = 1'b0;
    end
    if (mdu_valid && !full && mdu_rd != 0 && !(mw && mdu_rd == mem_rd))
      mq.push_back('{1'b1, mdu_rd, mdu_result});
    exp_mis = bad;
    if (acc) exp_ret = exp_ret + 1;
    @(posedge clk);
    #1;
    checkOutput("rf_wen", 32'(rf_wen), 32'(exp_wen));
    checkOutput("rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
    checkOutput("rf_wdata", rf_wdata, exp_wdata);
    checkOutput("wb_misalign", 32'(wb_misalign), 32'(exp_mis));
    checkOutput("wb_retired", wb_retired, exp_ret);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    applyIdle();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rf_wen", 32'(rf_wen), 32'd0);
    checkOutput("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
    checkOutput("reset_misalign", 32'(wb_misalign), 32'd0);
    checkOutput("reset_retired", wb_retired, 32'd0);
    checkOutput("reset_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("reset_mdu_ready", 32'(mdu_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_no_write", 32'(rf_wen), 32'd0);

    // Plain ALU write
    applyStimulus(1, 1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("lw_basic_waddr", 32'(rf_waddr), 32'd3);
    checkOutput("lw_basic_wdata", rf_wdata, 32'h12345678);
    checkOutput("lw_basic_retired", wb_retired, 32'd1);

    // Load extraction
    applyStimulus(1, 1, 6, 0, 1, 3'd1, 2'd2, 32'h0080FF00, 0, 0, 0);
    runCycle();
    checkOutput("lb_sext", rf_wdata, 32'hFFFFFF80);
    applyStimulus(1, 1, 6, 0, 1, 3'd2, 2'd2, 32'h0080FF00, 0, 0, 0);
    runCycle();
    checkOutput("lbu_zext", rf_wdata, 32'h00000080);
    applyStimulus(1, 1, 6, 0, 1, 3'd4, 2'd2, 32'h80010000, 0, 0, 0);
    runCycle();
    checkOutput("lhu_upper", rf_wdata, 32'h00008001);

    // Misaligned halfword
    applyStimulus(1, 1, 9, 0, 1, 3'd3, 2'd1, 32'hDEADBEEF, 0, 0, 0);
    runCycle();
    checkOutput("mis_no_write", 32'(rf_wen), 32'd0);
    checkOutput("mis_pulse", 32'(wb_misalign), 32'd1);
    checkOutput("mis_retired", wb_retired, 32'd5);
    applyIdle();
    runCycle();
    checkOutput("mis_pulse_end", 32'(wb_misalign), 32'd0);

    // Queue fills behind continuous MEM writes, then stalls MEM for one cycle
    applyStimulus(1, 1, 1, 32'h11, 0, 0, 0, 0, 1, 4, 32'h44);
    runCycle();
    applyStimulus(1, 1, 2, 32'h22, 0, 0, 0, 0, 1, 5, 32'h55);
    runCycle();
    applyStimulus(1, 1, 1, 32'h33, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_mem_ready_low", 32'(mem_ready), 32'd0);
    checkOutput("full_mdu_ready_low", 32'(mdu_ready), 32'd0);
    runCycle();
    checkOutput("drain_waddr", 32'(rf_waddr), 32'd4);
    checkOutput("drain_wdata", rf_wdata, 32'h44);
    checkOutput("drain_mem_ready_back", 32'(mem_ready), 32'd1);
    applyIdle();
    repeat (3) runCycle();

    // WAW cancellation of a queued entry
    applyStimulus(1, 1, 1, 32'h1, 0, 0, 0, 0, 1, 7, 32'hAAAA);
    runCycle();
    applyStimulus(1, 1, 7, 32'h5555, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("waw_wdata", rf_wdata, 32'h5555);
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      runCycle();
      checkOutput("waw_no_stale", 32'(rf_wen), 32'd0);
    end

    // Writes to x0 from each source
    applyStimulus(1, 1, 0, 32'hBAD0, 0, 0, 0, 0, 1, 0, 32'hBAD1);
    runCycle();
    checkOutput("x0_mem", 32'(rf_wen), 32'd0);
    applyIdle();
    runCycle();
    checkOutput("x0_mdu", 32'(rf_wen), 32'd0);

    // Reset with two entries queued
    applyStimulus(1, 1, 1, 32'h1, 0, 0, 0, 0, 1, 4, 32'h4);
    runCycle();
    applyStimulus(1, 1, 2, 32'h2, 0, 0, 0, 0, 1, 5, 32'h5);
    runCycle();
    applyIdle();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("midrst_rf_wen", 32'(rf_wen), 32'd0);
    checkOutput("midrst_retired", wb_retired, 32'd0);
    checkOutput("midrst_mdu_ready", 32'(mdu_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      runCycle();
      checkOutput("midrst_no_write", 32'(rf_wen), 32'd0);
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                    5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 1), 3'($urandom_range(0, 6)),
                    2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
      runCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
